ft_tx_pattern_gen: RTL and testbench
====================================

Name: ft_tx_pattern_gen

Overview:
- Parametrised FT600-style transmit test-pattern generator: emits bursts of one header word plus N payload words on an active-low write strobe.
- Respects FIFO-full back-pressure on every word, not only at burst start.
- Payload pattern, burst length, sleep gap and final-word byte enables are selectable at runtime.
- Sits between the FPGA test logic and the FT600 FIFO bus wrapper; used for host throughput and data-integrity tests.

Parameters:
DATA_W, 16, data bus width in bits; multiple of 8, at least 8.
BE_W, DATA_W/8, byte-enable width (derived).
MAX_BURST, 1024, maximum payload words per burst; power of two.
SLEEP_W, 16, width of the sleep_ticks input.
LFSR_POLY, 16'hB400, Galois LFSR feedback mask; width DATA_W.
LFSR_SEED, 16'h0001, LFSR seed reloaded at every burst start; must be nonzero.

Ports:
clk  in  1  single clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
en  in  1  allow new bursts to start.
mode  in  2  payload pattern: 0 = word index, 1 = walking one, 2 = LFSR, 3 = constant alternating 8'hA5 bytes.
burst_len  in  $clog2(MAX_BURST)  payload word count minus 1.
sleep_ticks  in  SLEEP_W  idle cycles after each burst; 0 means no sleep.
last_be  in  BE_W  byte enables for the final payload word; 0 is treated as all ones.
txen  in  1  FIFO full, active high; 0 means a word may be written.
wrn  out  1  write strobe, active low.
data  out  DATA_W  write data.
be  out  BE_W  byte enables.
burst_done  out  1  one-cycle pulse when a burst's final word is accepted.
cycle_cnt  out  DATA_W  header value of the next burst.

Behaviour:
- Reset values: wrn=1, data=0, be=0, burst_done=0, cycle_cnt=1, FSM in IDLE, all internal counters 0, LFSR=LFSR_SEED.
- All outputs are registered.

Transfer rule:
- A word transfers at a posedge where wrn==0 and txen==0.
- While wrn==0 and txen==1, data, be, wrn and all counters hold unchanged. No word is dropped or repeated.

FSM:
- IDLE: wrn=1, be=0, data holds its last value.
  - en==1 and txen==0: latch mode, burst_len, last_be and sleep_ticks into shadow registers, reload LFSR=LFSR_SEED, go to HEADER.
  - Outputs are registered, so the first wrn=0 appears on the cycle after the decision.
- HEADER: drive wrn=0, data=cycle_cnt, be=all ones. On transfer, go to PAYLOAD with word index = 0.
- PAYLOAD: drive wrn=0.
  - data for word index i, by latched mode:
    - mode 0: i zero-extended, or truncated to DATA_W.
    - mode 1: 1 << (i mod DATA_W).
    - mode 2: current LFSR value; the LFSR advances one step on each payload transfer (shift right, XOR LFSR_POLY if the shifted-out bit is 1).
    - mode 3: all bytes 8'hA5.
  - be = all ones, except when i == latched burst_len: be = latched last_be, or all ones if last_be is 0.
  - On transfer of the final word:
    - wrn=1 and be=0 next cycle, burst_done=1 for exactly that cycle.
    - cycle_cnt increments; 2^DATA_W-1 wraps to 1, so the header is never 0.
    - Go to SLEEP if latched sleep_ticks != 0, else to IDLE.
- SLEEP: wrn=1 for exactly latched sleep_ticks cycles, then IDLE.
- Back-to-back bursts (sleep_ticks=0, en=1, txen=0): exactly one wrn=1 cycle between bursts.

Boundaries:
- burst_len=0: header plus one payload word, which carries last_be.
- burst_len=MAX_BURST-1: index counter reaches its maximum with no overflow into the next burst.
- en deasserted mid-burst: the current burst and its sleep complete, then the FSM stays in IDLE.
- Config inputs changing mid-burst have no effect until the next burst start.
- txen rising on the same edge as the final word: that word is not transferred. burst_done fires only when the word is actually accepted.
- rst mid-burst: all outputs and state return to reset values on the next edge; cycle_cnt restarts at 1.

Test Plan:
- DATA_W=16, mode 0, burst_len=3, sleep_ticks=2, txen=0: wrn low 5 cycles with data 0001, 0000, 0001, 0002, 0003 and be=11; burst_done on the cycle after the last word; wrn high exactly 2 cycles before wrn low again; next header 0002.
- mode 0, burst_len=7, txen=1 on payload words 2 and 5 for 3 cycles each: data/be/wrn held during each stall; host sees indices 0..7 exactly once; 8 payload transfers total.
- mode 2, burst_len=3, seed 0001, poly B400: payload 0001, B400, 5A00, 2D00; identical sequence on the second burst.
- mode 1, burst_len=17, last_be=2'b01: payload 0001..8000, then 0001, 0002; be=01 on the final word only.
- Force cycle_cnt to FFFF via 65535 bursts (or DATA_W=8 build: 255 bursts): header after FF is 01, never 00.
- Reset mid-payload at word index 4, then burst_len=3: next edge wrn=1, be=0, burst_done=0; next header 0001. en=0 mid-burst: burst finishes, no further wrn low.

Source files
------------

// File: rtl/ft_tx_pattern_gen.sv
// ft_tx_pattern_gen: FT600-style transmit test-pattern generator.
// Emits one header word plus a payload burst on an active-low strobe, honouring txen on every word.
module ft_tx_pattern_gen #(
  parameter int                DATA_W    = 16,
  parameter int                BE_W      = DATA_W / 8,
  parameter int                MAX_BURST = 1024,
  parameter int                SLEEP_W   = 16,
  parameter logic [DATA_W-1:0] LFSR_POLY = 16'hB400,
  parameter logic [DATA_W-1:0] LFSR_SEED = 16'h0001
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic [$clog2(MAX_BURST)-1:0] burst_len,
  input  logic [SLEEP_W-1:0]           sleep_ticks,
  input  logic [BE_W-1:0]              last_be,
  input  logic                         txen,
  output logic                         wrn,
  output logic [DATA_W-1:0]            data,
  output logic [BE_W-1:0]              be,
  output logic                         burst_done,
  output logic [DATA_W-1:0]            cycle_cnt
);

  // state   | meaning
  // IDLE    | strobe high, waiting for en with the FIFO not full
  // HEADER  | presenting the cycle_cnt header word
  // PAYLOAD | presenting payload word idx
  // SLEEP   | strobe high for the latched sleep count; the last tick may relaunch

  localparam int LEN_W = $clog2(MAX_BURST);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_SLEEP
  } state_t;

  state_t               state, state_n;
  logic                 wrn_n, burst_done_n;
  logic [DATA_W-1:0]    data_n, cycle_cnt_n;
  logic [BE_W-1:0]      be_n;
  logic [LEN_W-1:0]     idx, idx_n;
  logic [DATA_W-1:0]    lfsr, lfsr_n;
  logic [1:0]           mode_q, mode_n;
  logic [LEN_W-1:0]     len_q, len_n;
  logic [BE_W-1:0]      last_be_q, last_be_n;
  logic [SLEEP_W-1:0]   sleep_q, sleep_n;
  logic [SLEEP_W-1:0]   sleep_cnt, sleep_cnt_n;

  logic                 xfer;
  logic                 start;
  logic                 launch;
  logic [LEN_W-1:0]     idx_inc;
  logic [DATA_W-1:0]    lfsr_step;
  logic [BE_W-1:0]      final_be;

  assign xfer      = !wrn && !txen;
  assign start     = en && !txen;
  assign idx_inc   = idx + LEN_W'(1);
  assign lfsr_step = {1'b0, lfsr[DATA_W-1:1]} ^ (lfsr[0] ? LFSR_POLY : '0);
  assign final_be  = (last_be_q == '0) ? '1 : last_be_q;

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        m,
                                                input logic [LEN_W-1:0]  i,
                                                input logic [DATA_W-1:0] l);
    case (m)
      2'd0:    pattern = DATA_W'(i);
      2'd1:    pattern = DATA_W'(1) << (int'(i) % DATA_W);
      2'd2:    pattern = l;
      default: pattern = {BE_W{8'hA5}};
    endcase
  endfunction

  always_comb begin
    state_n      = state;
    wrn_n        = wrn;
    data_n       = data;
    be_n         = be;
    burst_done_n = 1'b0;
    cycle_cnt_n  = cycle_cnt;
    idx_n        = idx;
    lfsr_n       = lfsr;
    mode_n       = mode_q;
    len_n        = len_q;
    last_be_n    = last_be_q;
    sleep_n      = sleep_q;
    sleep_cnt_n  = sleep_cnt;
    launch       = 1'b0;

    case (state)
      ST_IDLE: begin
        launch = start;
      end
      ST_HEADER: begin
        if (xfer) begin
          state_n = ST_PAYLOAD;
          idx_n   = '0;
          data_n  = pattern(mode_q, '0, lfsr);
          be_n    = (len_q == '0) ? final_be : '1;
        end
      end
      ST_PAYLOAD: begin
        if (xfer) begin
          lfsr_n = lfsr_step;
          if (idx == len_q) begin
            wrn_n        = 1'b1;
            be_n         = '0;
            burst_done_n = 1'b1;
            cycle_cnt_n  = (cycle_cnt == '1) ? DATA_W'(1) : cycle_cnt + DATA_W'(1);
            if (sleep_q != '0) begin
              state_n     = ST_SLEEP;
              sleep_cnt_n = sleep_q;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            idx_n  = idx_inc;
            data_n = pattern(mode_q, idx_inc, lfsr_step);
            be_n   = (idx_inc == len_q) ? final_be : '1;
          end
        end
      end
      ST_SLEEP: begin
        // The terminal sleep tick doubles as the idle decision, so the gap is exactly sleep_ticks.
        if (sleep_cnt == SLEEP_W'(1)) begin
          sleep_cnt_n = '0;
          state_n     = ST_IDLE;
          launch      = start;
        end else begin
          sleep_cnt_n = sleep_cnt - SLEEP_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (launch) begin
      state_n   = ST_HEADER;
      mode_n    = mode;
      len_n     = burst_len;
      last_be_n = last_be;
      sleep_n   = sleep_ticks;
      lfsr_n    = LFSR_SEED;
      wrn_n     = 1'b0;
      data_n    = cycle_cnt;
      be_n      = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wrn        <= 1'b1;
      data       <= '0;
      be         <= '0;
      burst_done <= 1'b0;
      cycle_cnt  <= DATA_W'(1);
      idx        <= '0;
      lfsr       <= LFSR_SEED;
      mode_q     <= '0;
      len_q      <= '0;
      last_be_q  <= '0;
      sleep_q    <= '0;
      sleep_cnt  <= '0;
    end else begin
      state      <= state_n;
      wrn        <= wrn_n;
      data       <= data_n;
      be         <= be_n;
      burst_done <= burst_done_n;
      cycle_cnt  <= cycle_cnt_n;
      idx        <= idx_n;
      lfsr       <= lfsr_n;
      mode_q     <= mode_n;
      len_q      <= len_n;
      last_be_q  <= last_be_n;
      sleep_q    <= sleep_n;
      sleep_cnt  <= sleep_cnt_n;
    end
  end

endmodule

// File: tb/tb_ft_tx_pattern_gen.sv
// Bench for ft_tx_pattern_gen: host-side reference model fed by directed and random stimulus.
// A second 8-bit instance exercises the header counter wrap.
module tb_ft_tx_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, txen;
  logic [1:0]  mode;
  logic [9:0]  burst_len;
  logic [15:0] sleep_ticks;
  logic [1:0]  last_be;
  logic        wrn, burst_done;
  logic [15:0] data, cycle_cnt;
  logic [1:0]  be;

  logic        en8, wrn8, done8;
  logic [7:0]  data8, cyc8;
  logic [0:0]  be8;

  ft_tx_pattern_gen dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .burst_len(burst_len),
    .sleep_ticks(sleep_ticks), .last_be(last_be), .txen(txen), .wrn(wrn),
    .data(data), .be(be), .burst_done(burst_done), .cycle_cnt(cycle_cnt)
  );

  ft_tx_pattern_gen #(.DATA_W(8), .LFSR_POLY(8'hB8), .LFSR_SEED(8'h01)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .mode(2'd0), .burst_len(10'd0),
    .sleep_ticks(16'd0), .last_be(1'b0), .txen(1'b0), .wrn(wrn8),
    .data(data8), .be(be8), .burst_done(done8), .cycle_cnt(cyc8)
  );

  int n_err = 0;
  int n_chk = 0;

  // host model state
  int          m_cyc = 1;
  logic [15:0] exp_d[$];
  logic [1:0]  exp_b[$];
  int          k = 0;
  bit          in_burst = 0;
  bit          prev_wrn = 1;
  int          hi_run = 0, last_gap = 0;
  int          n_started = 0, n_done = 0;
  int          xfers = 0, last_xfers = 0;
  logic [15:0] last_hdr = '0;
  int          m_cyc8 = 1, hdr8_cnt = 0;
  bit          prev_wrn8 = 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected words of a burst from the configuration sampled at its launch.
  task automatic build_burst();
    logic [15:0] v;
    logic [1:0]  lb;
    int          len;
    exp_d.delete();
    exp_b.delete();
    exp_d.push_back(16'(m_cyc));
    exp_b.push_back(2'b11);
    v   = 16'h0001;
    lb  = (last_be == 2'b00) ? 2'b11 : last_be;
    len = int'(burst_len);
    for (int i = 0; i <= len; i++) begin
      case (mode)
        2'd0: exp_d.push_back(16'(i));
        2'd1: exp_d.push_back(16'(1 << (i % 16)));
        2'd2: begin
          exp_d.push_back(v);
          v = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
        end
        default: exp_d.push_back(16'hA5A5);
      endcase
      exp_b.push_back((i == len) ? lb : 2'b11);
    end
  endtask

  // Called at each falling edge; inputs still hold what the last rising edge sampled.
  task automatic monitor();
    bit xfer;
    bit done_exp;
    if (rst) begin
      chk("rst_wrn", wrn, 1);
      chk("rst_be", be, 0);
      chk("rst_data", data, 0);
      chk("rst_done", burst_done, 0);
      chk("rst_cyc", cycle_cnt, 1);
      m_cyc = 1; in_burst = 0; k = 0; hi_run = 0; prev_wrn = 1;
      m_cyc8 = 1; prev_wrn8 = 1;
      return;
    end
    xfer     = in_burst && !prev_wrn && !txen;
    done_exp = 0;
    if (xfer) begin
      k++;
      xfers++;
      if (k == exp_d.size()) begin
        done_exp   = 1;
        in_burst   = 0;
        n_done++;
        last_xfers = xfers;
        hi_run     = 0;
        m_cyc      = (m_cyc == 16'hFFFF) ? 1 : m_cyc + 1;
      end
    end
    chk("burst_done", burst_done, done_exp);
    chk("cycle_cnt", cycle_cnt, m_cyc);
    if (!wrn && !in_burst) begin
      chk("launch_en", en, 1);
      chk("launch_txen", txen, 0);
      build_burst();
      in_burst = 1; k = 0; xfers = 0;
      last_gap = hi_run;
      last_hdr = 16'(m_cyc);
      n_started++;
    end
    if (in_burst) begin
      chk("wrn_low", wrn, 0);
      if (!wrn) begin
        chk("data", data, exp_d[k]);
        chk("be", be, exp_b[k]);
      end
    end else if (wrn) begin
      hi_run++;
    end
    prev_wrn = wrn;
    if (!wrn8 && prev_wrn8) begin
      chk("hdr8", data8, m_cyc8);
      m_cyc8 = (m_cyc8 == 255) ? 1 : m_cyc8 + 1;
      hdr8_cnt++;
    end
    prev_wrn8 = wrn8;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    int target = n_done + n;
    int c = 0;
    while (n_done < target && c < budget) begin
      tick();
      c++;
    end
    if (n_done < target) chk(tag, n_done, target);
  endtask

  task automatic wait_start(input string tag);
    int c = 0;
    while (!in_burst && c < 50) begin
      tick();
      c++;
    end
    chk(tag, in_burst, 1);
  endtask

  initial begin
    int c, n0, stall_left;
    bit s2, s5;
    rst = 1; en = 0; txen = 0; mode = 0; burst_len = 0; sleep_ticks = 0; last_be = 0; en8 = 0;
    repeat (3) tick();
    rst = 0;

    // index pattern with a 2-cycle sleep
    mode = 2'd0; burst_len = 10'd3; sleep_ticks = 16'd2; en = 1;
    wait_done(2, 100, "t1_timeout");
    chk("t1_hdr2", last_hdr, 16'h0002);
    chk("t1_gap", last_gap, 2);

    // back-to-back with no sleep
    sleep_ticks = 16'd0;
    wait_done(3, 100, "t2_timeout");
    chk("t2_gap", last_gap, 1);

    // LFSR pattern, reseeded every burst
    mode = 2'd2; burst_len = 10'd3;
    wait_done(3, 100, "t3_timeout");

    // walking one with partial final byte enable
    mode = 2'd1; burst_len = 10'd17; last_be = 2'b01;
    wait_done(2, 200, "t4_timeout");

    // stalls on payload 2 and 5; en drops mid-burst
    en = 0; mode = 2'd0; burst_len = 10'd7; last_be = 2'b00; sleep_ticks = 16'd0;
    tick();
    en = 1;
    wait_start("t5_start");
    en = 0;
    stall_left = 0; s2 = 0; s5 = 0; c = 0;
    while (in_burst && c < 100) begin
      if (k == 3 && !s2) begin s2 = 1; stall_left = 3; end
      if (k == 6 && !s5) begin s5 = 1; stall_left = 3; end
      txen = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      tick();
      c++;
    end
    txen = 0;
    chk("t5_end", in_burst, 0);
    chk("t5_xfers", last_xfers, 9);
    n0 = n_started;
    repeat (30) tick();
    chk("t5_en_off", n_started, n0);

    // longest burst
    burst_len = 10'h3FF; en = 1;
    wait_start("t6_start");
    en = 0;
    wait_done(1, 1200, "t6_timeout");
    chk("t6_xfers", last_xfers, 1025);

    // reset at payload index 4
    burst_len = 10'd10; en = 1;
    wait_start("t7_start");
    c = 0;
    while (k < 5 && c < 50) begin
      tick();
      c++;
    end
    chk("t7_idx", k, 5);
    rst = 1;
    tick();
    rst = 0; burst_len = 10'd3;
    wait_done(1, 50, "t7_timeout");
    chk("t7_hdr", last_hdr, 16'h0001);

    // random configuration, enable and back-pressure on every cycle
    n0 = n_done;
    for (int i = 0; i < 3000; i++) begin
      en          = ($urandom_range(9) != 0);
      txen        = ($urandom_range(3) == 0);
      mode        = 2'($urandom_range(3));
      burst_len   = 10'($urandom_range(15));
      sleep_ticks = 16'($urandom_range(3));
      last_be     = 2'($urandom_range(3));
      tick();
    end
    en = 0; txen = 0;
    c = 0;
    while ((in_burst || hi_run < 6) && c < 100) begin
      tick();
      c++;
    end
    chk("rand_idle", in_burst, 0);
    chk("rand_progress", (n_done - n0) > 50, 1);

    // 8-bit header wrap: FF is followed by 01
    rst = 1;
    tick();
    rst = 0; hdr8_cnt = 0; en8 = 1;
    c = 0;
    while (hdr8_cnt < 257 && c < 1200) begin
      tick();
      c++;
    end
    en8 = 0;
    chk("hdr8_count", hdr8_cnt, 257);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
